systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Operand transmitter for the 8x8 systolic array. Accepts one K-slice per beat (8 A-elements for the rows, 8 B-elements for the columns) over valid/ready streams. Skews each lane diagonally (row/column i delayed i cycles) and drives the array's left-edge (`enleft`/`aleft`/`cmleft`) and top-edge (`enup`/`bup`/`cmup`) inputs. Sits between the operand buffers and the array; one tile per `start`.

## Interface
- `LANES`, 8, rows of A = columns of B = skew lanes
- `DATA_W`, 32, operand width
- `KW`, 9, width of `k_len` (tile depth 1..256)
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  begin a tile; sampled only in IDLE
- `k_len`  in  KW  beats in the tile, latched with `start`; legal 1..256
- `a_valid`  in  1  A-slice available
- `a_ready`  out  1  A-slice consumed this cycle if valid
- `a_data`  in  LANES x DATA_W  A[i][k]; element i goes to row i
- `b_valid`  in  1  B-slice available
- `b_ready`  out  1  B-slice consumed this cycle if valid
- `b_data`  in  LANES x DATA_W  B[k][j]; element j goes to column j
- `enleft`, `cmleft`  out  LANES  row-edge enable / commit
- `aleft`  out  LANES x DATA_W  row-edge operand
- `enup`, `cmup`  out  LANES  column-edge enable / commit
- `bup`  out  LANES x DATA_W  column-edge operand
- `busy`  out  1  high in FEED and DRAIN
- `done`  out  1  one-cycle pulse when the last skewed beat has left the edge

## Operation
- States:
  - IDLE: `start` with `k_len != 0` latches `k_len`, clears the beat counter, and moves to FEED. `start` with `k_len == 0` is ignored.
  - FEED: accepts beats. After beat number `k_len` is accepted, moves to DRAIN with the drain counter set to 7.
  - DRAIN: decrements the counter each cycle. At 0, moves to DONE.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Joint handshake: `a_ready = (FEED) && b_valid`; `b_ready = (FEED) && a_valid`. A beat transfers only when both sides are valid in FEED. A lone valid is not consumed, and its data must be held by the source.
- Transfer injects lane word {en=1, cm=(beat==k_len-1), data} into every lane's delay line. A non-transfer cycle injects a bubble {en=0, cm=0, data=0}.
- Delay lines shift every cycle unconditionally. Bubbles propagate, so inter-lane alignment is preserved under backpressure.
- Row lane i carries `a_data[i]`; column lane j carries `b_data[j]`. Both use identical delay depth for identical index.
- `aleft`/`bup` are 0 whenever the matching `en` is 0. `cm` is never high without `en`.
- `start` outside IDLE is ignored. Input `k_len` changes after latch have no effect.

## Timing
- Reset value, all outputs: 0, i.e. `a_ready`, `b_ready`, `en*`, `cm*`, `aleft`, `bup`, `busy`, `done` all 0. State = IDLE; all delay-line stages cleared.
- Lane latency: a beat transferred in cycle t appears on lane i in cycle t+1+i. This covers both edges.
- `busy` rises the cycle after accepted `start`. `a_ready`/`b_ready` can be high from that cycle.
- Drain: with the last transfer in cycle T, lane 7 emits `cm=1` in T+8 and `done` pulses in T+9. `busy` is low in T+9.
- Minimum tile length, start to done, with no stalls: `k_len + 9` cycles after the `start` cycle.
- Reset mid-operation: the next cycle has all outputs 0, the state is IDLE, in-flight beats are dropped, and no `done` is generated.
- Beat counter wraps nowhere. KW holds 256, and the counter compares against `k_len-1`.

## Structure
- `para_pkg` (package `params`) gains:
  - `FEED_LANES=8`, `FEED_DW=32`
  - `feeder_state_t` enum {IDLE, FEED, DRAIN, DONE}
  - `lane_word_t` packed struct {en, cm, data[31:0]}
- Sub-module `skew_delay_line #(DEPTH, type T)`: a DEPTH+1 stage synchronous-reset shift register of `lane_word_t`. It is instantiated 2 x LANES times with DEPTH = lane index.
- Top module: FSM, beat counter, drain counter, handshake, and lane-word packing/unpacking.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs -> every output 0 during and 1 cycle after reset.
- `k_len=1`, A=i+1, B=0x10+j, both valid, transfer at t -> lane i has en=cm=1, `aleft[i]=i+1` / `bup[i]=0x10+i` at t+1+i, and is 0 otherwise. `done` pulses at t+9.
- `k_len=4`, continuous valids, A beat k = 0x100*k+i -> lane 3 shows 0x003, 0x103, 0x203, 0x303 on cycles t+4..t+7. `cm` is high only with 0x303.
- Backpressure: `b_valid` low on alternate cycles, `a_valid` constant -> `a_ready` low whenever `b_valid` low. Each lane shows the same en pattern 1,0,1,0 shifted by its index. No beat is lost or duplicated.
- `start` during FEED, and `start` with `k_len=0` in IDLE -> both ignored: `busy` unchanged, and one `done` per legal tile.
- `rst` in the cycle after the 2nd transfer of a `k_len=8` tile -> outputs 0 next cycle and no `done`. A new `start` then runs a clean tile.

Source files
------------

// File: rtl/systolic_feeder_pkg.sv
// -----------------------------------------------------------------------------
// systolic_feeder_pkg
// Shared types and constants for the systolic-array operand feeder.
//   FEED_LANES      number of skew lanes (rows of A / columns of B)
//   FEED_DW         operand width carried per lane
//   feeder_state_t  feeder FSM encoding
//   lane_word_t     one delay-line entry: enable, commit, operand
//   make_lane_word  builds the word injected into a lane each cycle
// -----------------------------------------------------------------------------
package systolic_feeder_pkg;

    localparam int FEED_LANES = 8;
    localparam int FEED_DW    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    typedef struct packed {
        logic               en;
        logic               cm;
        logic [FEED_DW-1:0] data;
    } lane_word_t;

    // A non-transfer cycle injects an all-zero bubble so lanes stay aligned.
    function automatic lane_word_t make_lane_word(
        input logic               xfer,
        input logic               last,
        input logic [FEED_DW-1:0] d
    );
        lane_word_t w;
        w = '0;
        if (xfer) begin
            w.en   = 1'b1;
            w.cm   = last;
            w.data = d;
        end
        return w;
    endfunction

endpackage

// File: rtl/systolic_feeder_skew_delay_line.sv
// -----------------------------------------------------------------------------
// systolic_feeder_skew_delay_line
// Fixed-depth shift register that delays one lane by DEPTH extra cycles.
// A word presented on din in cycle t appears on dout in cycle t+1+DEPTH.
// Shifts every cycle; synchronous active-high reset clears every stage.
//   clk   clock
//   rst   synchronous reset, active high
//   din   word entering the lane
//   dout  word leaving the lane
// -----------------------------------------------------------------------------
module systolic_feeder_skew_delay_line
    import systolic_feeder_pkg::*;
#(
    parameter int  DEPTH = 0,
    parameter type T     = lane_word_t
) (
    input  logic clk,
    input  logic rst,
    input  T     din,
    output T     dout
);

    T stage_q [DEPTH+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= DEPTH; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int s = 1; s <= DEPTH; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign dout = stage_q[DEPTH];

endmodule

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
// Operand transmitter for an LANES x LANES systolic array. Takes one K-slice
// per beat (A column + B row) over a joint valid/ready handshake, skews lane i
// by i cycles and drives the array's left edge (rows) and top edge (columns).
//   clk, rst                clock, synchronous active-high reset
//   start, k_len            begin a tile of k_len beats (sampled in IDLE only)
//   a_valid/a_ready/a_data  A-slice stream, element i -> row i
//   b_valid/b_ready/b_data  B-slice stream, element j -> column j
//   enleft/cmleft/aleft     row-edge enable / commit / operand
//   enup/cmup/bup           column-edge enable / commit / operand
//   busy                    high in FEED and DRAIN
//   done                    one-cycle pulse once the last skewed beat has left
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start with a non-zero k_len
// FEED  | accepting beats until k_len have transferred
// DRAIN | counting LANES-1 cycles while the deepest lane empties
// DONE  | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int DATA_W = 32,
    parameter int KW     = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [KW-1:0]                k_len,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic [LANES-1:0][DATA_W-1:0] a_data,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic [LANES-1:0][DATA_W-1:0] b_data,
    output logic [LANES-1:0]             enleft,
    output logic [LANES-1:0]             cmleft,
    output logic [LANES-1:0][DATA_W-1:0] aleft,
    output logic [LANES-1:0]             enup,
    output logic [LANES-1:0]             cmup,
    output logic [LANES-1:0][DATA_W-1:0] bup,
    output logic                         busy,
    output logic                         done
);

    localparam int            DCW         = $clog2(LANES);
    localparam logic [DCW-1:0] DRAIN_START = DCW'(LANES - 1);

    feeder_state_t  state_q;
    logic [KW-1:0]  k_len_q;
    logic [KW-1:0]  beat_q;
    logic [DCW-1:0] drain_q;

    logic in_feed;
    logic xfer;
    logic last_beat;

    assign in_feed = (state_q == FEED);

    // Each side's ready depends on the other's valid, so a lone valid is
    // never consumed and both slices always move together.
    assign a_ready = in_feed && b_valid;
    assign b_ready = in_feed && a_valid;
    assign xfer    = in_feed && a_valid && b_valid;

    // k_len_q is never 0 in FEED, so k_len_q-1 cannot underflow; 256 fits KW.
    assign last_beat = (beat_q == k_len_q - KW'(1));

    assign busy = (state_q == FEED) || (state_q == DRAIN);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_len_q <= '0;
            beat_q  <= '0;
            drain_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (k_len != '0)) begin
                        k_len_q <= k_len;
                        beat_q  <= '0;
                        state_q <= FEED;
                    end
                end
                FEED: begin
                    if (xfer) begin
                        if (last_beat) begin
                            drain_q <= DRAIN_START;
                            state_q <= DRAIN;
                        end else begin
                            beat_q <= beat_q + KW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        drain_q <= drain_q - DCW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    lane_word_t row_in  [LANES];
    lane_word_t row_out [LANES];
    lane_word_t col_in  [LANES];
    lane_word_t col_out [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign row_in[i] = make_lane_word(xfer, last_beat, a_data[i]);
        assign col_in[i] = make_lane_word(xfer, last_beat, b_data[i]);

        systolic_feeder_skew_delay_line #(
            .DEPTH (i),
            .T     (lane_word_t)
        ) u_row (
            .clk  (clk),
            .rst  (rst),
            .din  (row_in[i]),
            .dout (row_out[i])
        );

        systolic_feeder_skew_delay_line #(
            .DEPTH (i),
            .T     (lane_word_t)
        ) u_col (
            .clk  (clk),
            .rst  (rst),
            .din  (col_in[i]),
            .dout (col_out[i])
        );

        // Masking keeps the edge clean even if a stage ever held stale data.
        assign enleft[i] = row_out[i].en;
        assign cmleft[i] = row_out[i].en & row_out[i].cm;
        assign aleft[i]  = row_out[i].en ? row_out[i].data : '0;

        assign enup[i]   = col_out[i].en;
        assign cmup[i]   = col_out[i].en & col_out[i].cm;
        assign bup[i]    = col_out[i].en ? col_out[i].data : '0;
    end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [8:0]       k_len;
    logic             a_valid, b_valid;
    logic             a_ready, b_ready;
    logic [7:0][31:0] a_data, b_data;
    logic [7:0]       enleft, cmleft, enup, cmup;
    logic [7:0][31:0] aleft, bup;
    logic             busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    // Injection history of the current scenario, indexed by relative cycle.
    logic             h_en [64];
    logic             h_cm [64];
    logic [7:0][31:0] h_a  [64];
    logic [7:0][31:0] h_b  [64];

    always #5 clk = ~clk;

    systolic_feeder dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .k_len   (k_len),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_data  (b_data),
        .enleft  (enleft),
        .cmleft  (cmleft),
        .aleft   (aleft),
        .enup    (enup),
        .cmup    (cmup),
        .bup     (bup),
        .busy    (busy),
        .done    (done)
    );

    task automatic idle_inputs();
        start   = 1'b0;
        k_len   = '0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = '0;
        b_data  = '0;
    endtask

    task automatic random_inputs();
        start   = 1'($urandom_range(0, 1));
        k_len   = 9'($urandom_range(0, 511));
        a_valid = 1'($urandom_range(0, 1));
        b_valid = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) begin
            a_data[i] = $urandom();
            b_data[i] = $urandom();
        end
    endtask

    task automatic clear_hist();
        for (int r = 0; r < 64; r++) begin
            h_en[r] = 1'b0;
            h_cm[r] = 1'b0;
            h_a[r]  = '0;
            h_b[r]  = '0;
        end
    endtask

    task automatic record(input int r, input logic xfer, input logic last);
        h_en[r] = xfer;
        h_cm[r] = xfer & last;
        h_a[r]  = xfer ? a_data : '0;
        h_b[r]  = xfer ? b_data : '0;
    endtask

    // Lane i at cycle r shows what was injected at cycle r-1-i.
    function automatic logic [15:0] exp_ec(input int r);
        logic [7:0] e, c;
        e = '0;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            if (r - 1 - i >= 0) begin
                e[i] = h_en[r-1-i];
                c[i] = h_cm[r-1-i];
            end
        end
        return {e, c};
    endfunction

    function automatic logic [7:0][31:0] exp_a(input int r);
        logic [7:0][31:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            if (r - 1 - i >= 0) v[i] = h_a[r-1-i][i];
        end
        return v;
    endfunction

    function automatic logic [7:0][31:0] exp_b(input int r);
        logic [7:0][31:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            if (r - 1 - i >= 0) v[i] = h_b[r-1-i][i];
        end
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        random_inputs();
        @(posedge clk); #1;
        random_inputs();
        @(negedge clk);
        n_cmp++;
        if ({a_ready, b_ready, busy, done, enleft, cmleft, enup, cmup} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_ctrl got %h want 0", {a_ready, b_ready, busy, done, enleft, cmleft, enup, cmup});
        end
        n_cmp++;
        if ({aleft, bup} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got %h want 0", {aleft, bup});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        random_inputs();
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_ready, b_ready, busy, done, enleft, cmleft, enup, cmup} !== 36'h0) begin
            n_bad++;
            $display("FAIL post_reset_ctrl got %h want 0", {a_ready, b_ready, busy, done, enleft, cmleft, enup, cmup});
        end
        n_cmp++;
        if ({aleft, bup} !== '0) begin
            n_bad++;
            $display("FAIL post_reset_data got %h want 0", {aleft, bup});
        end
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    // k_len=1: start at r0, transfer at r1, done at r10.
    task automatic test_single();
        clear_hist();
        for (int r = 0; r < 12; r++) begin
            idle_inputs();
            if (r == 0) begin
                start = 1'b1;
                k_len = 9'd1;
            end
            if (r == 1) begin
                a_valid = 1'b1;
                b_valid = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    a_data[i] = 32'(i + 1);
                    b_data[i] = 32'(16 + i);
                end
            end
            record(r, r == 1, 1'b1);
            @(negedge clk);
            if (r == 1) begin
                n_cmp++;
                if ({a_ready, b_ready} !== 2'b11) begin
                    n_bad++;
                    $display("FAIL single_ready r=%0d got %b want 11", r, {a_ready, b_ready});
                end
            end
            if (r == 9) begin
                n_cmp++;
                if ({cmleft[7], aleft[7], bup[7]} !== {1'b1, 32'd8, 32'h17}) begin
                    n_bad++;
                    $display("FAIL single_lane7 got cm=%b a=%h b=%h want cm=1 a=8 b=17", cmleft[7], aleft[7], bup[7]);
                end
            end
            n_cmp++;
            if ({enleft, cmleft} !== exp_ec(r)) begin
                n_bad++;
                $display("FAIL single_left_en r=%0d got %h want %h", r, {enleft, cmleft}, exp_ec(r));
            end
            n_cmp++;
            if ({enup, cmup} !== exp_ec(r)) begin
                n_bad++;
                $display("FAIL single_up_en r=%0d got %h want %h", r, {enup, cmup}, exp_ec(r));
            end
            n_cmp++;
            if ({aleft, bup} !== {exp_a(r), exp_b(r)}) begin
                n_bad++;
                $display("FAIL single_data r=%0d got %h want %h", r, {aleft, bup}, {exp_a(r), exp_b(r)});
            end
            n_cmp++;
            if ({busy, done} !== {(r >= 1 && r <= 9), (r == 10)}) begin
                n_bad++;
                $display("FAIL single_busy_done r=%0d got %b want %b", r, {busy, done}, {(r >= 1 && r <= 9), (r == 10)});
            end
            @(posedge clk); #1;
        end
    endtask

    // k_len=4, valids held high throughout: beats r1..r4, done at r13.
    task automatic test_k4();
        clear_hist();
        for (int r = 0; r < 15; r++) begin
            idle_inputs();
            if (r == 0) begin
                start = 1'b1;
                k_len = 9'd4;
            end else begin
                a_valid = 1'b1;
                b_valid = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    a_data[i] = 32'(256 * (r - 1) + i);
                    b_data[i] = 32'(4096 + 256 * (r - 1) + i);
                end
            end
            record(r, r >= 1 && r <= 4, r == 4);
            @(negedge clk);
            n_cmp++;
            if ({a_ready, b_ready} !== {2{r >= 1 && r <= 4}}) begin
                n_bad++;
                $display("FAIL k4_ready r=%0d got %b want %b", r, {a_ready, b_ready}, {2{r >= 1 && r <= 4}});
            end
            if (r >= 5 && r <= 8) begin
                n_cmp++;
                if ({cmleft[3], aleft[3]} !== {r == 8, 32'(256 * (r - 5) + 3)}) begin
                    n_bad++;
                    $display("FAIL k4_lane3 r=%0d got cm=%b a=%h want cm=%b a=%h", r, cmleft[3], aleft[3], r == 8, 32'(256 * (r - 5) + 3));
                end
            end
            n_cmp++;
            if ({enleft, cmleft, enup, cmup} !== {exp_ec(r), exp_ec(r)}) begin
                n_bad++;
                $display("FAIL k4_en r=%0d got %h want %h", r, {enleft, cmleft, enup, cmup}, {exp_ec(r), exp_ec(r)});
            end
            n_cmp++;
            if ({aleft, bup} !== {exp_a(r), exp_b(r)}) begin
                n_bad++;
                $display("FAIL k4_data r=%0d got %h want %h", r, {aleft, bup}, {exp_a(r), exp_b(r)});
            end
            n_cmp++;
            if ({busy, done} !== {(r >= 1 && r <= 12), (r == 13)}) begin
                n_bad++;
                $display("FAIL k4_busy_done r=%0d got %b want %b", r, {busy, done}, {(r >= 1 && r <= 12), (r == 13)});
            end
            @(posedge clk); #1;
        end
    endtask

    // b_valid only on odd cycles: beats at r1,3,5,7, done at r16.
    task automatic test_backpressure();
        int   nb;
        logic feed_now;
        logic xfer;
        clear_hist();
        nb = 0;
        for (int r = 0; r < 19; r++) begin
            idle_inputs();
            if (r == 0) begin
                start = 1'b1;
                k_len = 9'd4;
            end else begin
                a_valid = 1'b1;
                b_valid = (r % 2) == 1;
                for (int i = 0; i < 8; i++) begin
                    a_data[i] = 32'(512 + 16 * nb + i);
                    b_data[i] = 32'(768 + 16 * nb + i);
                end
            end
            feed_now = (r >= 1) && (nb < 4);
            xfer     = feed_now && b_valid;
            record(r, xfer, nb == 3);
            @(negedge clk);
            n_cmp++;
            if ({a_ready, b_ready} !== {feed_now && b_valid, feed_now}) begin
                n_bad++;
                $display("FAIL bp_ready r=%0d got %b want %b", r, {a_ready, b_ready}, {feed_now && b_valid, feed_now});
            end
            n_cmp++;
            if ({enleft, cmleft, enup, cmup} !== {exp_ec(r), exp_ec(r)}) begin
                n_bad++;
                $display("FAIL bp_en r=%0d got %h want %h", r, {enleft, cmleft, enup, cmup}, {exp_ec(r), exp_ec(r)});
            end
            n_cmp++;
            if ({aleft, bup} !== {exp_a(r), exp_b(r)}) begin
                n_bad++;
                $display("FAIL bp_data r=%0d got %h want %h", r, {aleft, bup}, {exp_a(r), exp_b(r)});
            end
            n_cmp++;
            if ({busy, done} !== {(r >= 1 && r <= 15), (r == 16)}) begin
                n_bad++;
                $display("FAIL bp_busy_done r=%0d got %b want %b", r, {busy, done}, {(r >= 1 && r <= 15), (r == 16)});
            end
            if (xfer) nb++;
            @(posedge clk); #1;
        end
    endtask

    // start with k_len=0 ignored; legal k_len=2 tile at r2; stray starts ignored.
    task automatic test_ignored_start();
        int ndone;
        clear_hist();
        ndone = 0;
        for (int r = 0; r < 17; r++) begin
            idle_inputs();
            if (r == 0) begin
                start = 1'b1;
                k_len = 9'd0;
            end
            if (r == 2) begin
                start = 1'b1;
                k_len = 9'd2;
            end
            if (r == 3 || r == 4) begin
                start   = 1'b1;
                k_len   = (r == 3) ? 9'd5 : 9'd7;
                a_valid = 1'b1;
                b_valid = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    a_data[i] = 32'(1024 + 16 * r + i);
                    b_data[i] = 32'(2048 + 16 * r + i);
                end
            end
            if (r == 6) begin
                start = 1'b1;
                k_len = 9'd3;
            end
            record(r, r == 3 || r == 4, r == 4);
            @(negedge clk);
            if (done) ndone++;
            n_cmp++;
            if ({busy, done} !== {(r >= 3 && r <= 12), (r == 13)}) begin
                n_bad++;
                $display("FAIL ign_busy_done r=%0d got %b want %b", r, {busy, done}, {(r >= 3 && r <= 12), (r == 13)});
            end
            n_cmp++;
            if ({enleft, cmleft, enup, cmup} !== {exp_ec(r), exp_ec(r)}) begin
                n_bad++;
                $display("FAIL ign_en r=%0d got %h want %h", r, {enleft, cmleft, enup, cmup}, {exp_ec(r), exp_ec(r)});
            end
            n_cmp++;
            if ({aleft, bup} !== {exp_a(r), exp_b(r)}) begin
                n_bad++;
                $display("FAIL ign_data r=%0d got %h want %h", r, {aleft, bup}, {exp_a(r), exp_b(r)});
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (ndone !== 1) begin
            n_bad++;
            $display("FAIL ign_done_count got %0d want 1", ndone);
        end
    endtask

    // k_len=8, two beats at r1,r2, reset at r3: r4 onward quiet, no done.
    task automatic test_mid_reset();
        int ndone;
        ndone = 0;
        for (int r = 0; r < 16; r++) begin
            idle_inputs();
            rst = (r == 3);
            if (r == 0) begin
                start = 1'b1;
                k_len = 9'd8;
            end
            if (r >= 1 && r <= 3) begin
                a_valid = 1'b1;
                b_valid = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    a_data[i] = 32'(4096 + 16 * r + i);
                    b_data[i] = 32'(8192 + 16 * r + i);
                end
            end
            @(negedge clk);
            if (r >= 4) begin
                if (done) ndone++;
                n_cmp++;
                if ({a_ready, b_ready, busy, done, enleft, cmleft, enup, cmup} !== 36'h0) begin
                    n_bad++;
                    $display("FAIL mid_rst_ctrl r=%0d got %h want 0", r, {a_ready, b_ready, busy, done, enleft, cmleft, enup, cmup});
                end
                n_cmp++;
                if ({aleft, bup} !== '0) begin
                    n_bad++;
                    $display("FAIL mid_rst_data r=%0d got %h want 0", r, {aleft, bup});
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        n_cmp++;
        if (ndone !== 0) begin
            n_bad++;
            $display("FAIL mid_rst_done_count got %0d want 0", ndone);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_k4();
        test_backpressure();
        test_ignored_start();
        test_mid_reset();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
